// File: rtl/lagd_dec_pkg.sv
// Shared types, register offsets and the reset-time rule table for the LAGD
// programmable address decoder.
package lagd_dec_pkg;

  localparam int          NUM_ISING_ISLANDS       = 4;
  localparam logic [63:0] L2_MEM_BASE_ADDR        = 64'h0000_0000_7000_0000;
  localparam logic [63:0] L2_MEM_SIZE             = 64'h0000_0000_1000_0000;
  localparam logic [63:0] ISING_ISLANDS_BASE_ADDR = 64'h0000_0000_8000_0000;
  localparam logic [63:0] MAX_MEM_PER_ISLAND      = 64'h0000_0000_0100_0000;

  localparam logic [11:0] REG_LOCK      = 12'h000;
  localparam logic [11:0] REG_MISS_CNT  = 12'h004;
  localparam logic [11:0] REG_RULE_BASE = 12'h100;

  localparam logic [4:0] OFF_START_LO = 5'h00;
  localparam logic [4:0] OFF_START_HI = 5'h04;
  localparam logic [4:0] OFF_END_LO   = 5'h08;
  localparam logic [4:0] OFF_END_HI   = 5'h0C;
  localparam logic [4:0] OFF_CTRL     = 5'h10;

  typedef struct packed {
    logic [63:0] start_addr;
    logic [63:0] end_addr;
    logic [7:0]  idx;
    logic        en;
  } rule_t;

  // Rule 0 is L2, rules 1..N are the Ising islands; the rest are disabled with start > end.
  function automatic rule_t rst_rule(input int r);
    rule_t rule;
    rule.start_addr = 64'd1;
    rule.end_addr   = 64'd0;
    rule.idx        = 8'd0;
    rule.en         = 1'b0;
    if (r == 0) begin
      rule.start_addr = L2_MEM_BASE_ADDR;
      rule.end_addr   = L2_MEM_BASE_ADDR + L2_MEM_SIZE - 64'd1;
      rule.en         = 1'b1;
    end else if (r <= NUM_ISING_ISLANDS) begin
      rule.start_addr = ISING_ISLANDS_BASE_ADDR + 64'(r - 1) * MAX_MEM_PER_ISLAND;
      rule.end_addr   = rule.start_addr + MAX_MEM_PER_ISLAND - 64'd1;
      rule.idx        = 8'(r);
      rule.en         = 1'b1;
    end
    return rule;
  endfunction

  function automatic logic [63:0] rst_start(input int r);
    rule_t rule;
    rule = rst_rule(r);
    return rule.start_addr;
  endfunction

  function automatic logic [63:0] rst_end(input int r);
    rule_t rule;
    rule = rst_rule(r);
    return rule.end_addr;
  endfunction

  function automatic logic [7:0] rst_idx(input int r);
    rule_t rule;
    rule = rst_rule(r);
    return rule.idx;
  endfunction

  function automatic logic rst_en(input int r);
    rule_t rule;
    rule = rst_rule(r);
    return rule.en;
  endfunction

endpackage

// File: rtl/lagd_dec_match.sv
// Combinational priority matcher: the lowest-numbered enabled rule whose
// inclusive [start, end] window contains the address wins.
module lagd_dec_match #(
  parameter int unsigned NumRules  = 8,
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned IdxWidth  = 4
) (
  input  logic [AddrWidth-1:0] start_i [NumRules],
  input  logic [AddrWidth-1:0] end_i   [NumRules],
  input  logic [IdxWidth-1:0]  idx_i   [NumRules],
  input  logic [NumRules-1:0]  en_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic [IdxWidth-1:0]  idx_o,
  output logic                 hit_o
);

  // Scanning from the top down lets the lowest matching rule overwrite the rest.
  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    for (int r = int'(NumRules) - 1; r >= 0; r--) begin
      if (en_i[r] && (start_i[r] <= addr_i) && (addr_i <= end_i[r])) begin
        idx_o = idx_i[r];
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lagd_prog_addr_decoder.sv
// Runtime-programmable address decoder: register-programmable rule table,
// one-stage lookup pipeline with valid/ready, lock and decode-miss counter.
module lagd_prog_addr_decoder
  import lagd_dec_pkg::*;
#(
  parameter int unsigned         NumRules   = 8,
  parameter int unsigned         AddrWidth  = 48,
  parameter int unsigned         IdxWidth   = 4,
  parameter logic [IdxWidth-1:0] DefaultIdx = '0,
  parameter bit                  DefaultEn  = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [11:0]          cfg_addr_i,
  input  logic [31:0]          cfg_wdata_i,
  output logic                 cfg_gnt_o,
  output logic [31:0]          cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 lk_valid_i,
  output logic                 lk_ready_o,
  input  logic [AddrWidth-1:0] lk_addr_i,
  output logic                 rs_valid_o,
  input  logic                 rs_ready_i,
  output logic [IdxWidth-1:0]  rs_idx_o,
  output logic                 rs_hit_o,
  output logic                 rs_decerr_o
);

  logic [AddrWidth-1:0] start_q [NumRules];
  logic [AddrWidth-1:0] start_d [NumRules];
  logic [AddrWidth-1:0] end_q   [NumRules];
  logic [AddrWidth-1:0] end_d   [NumRules];
  logic [IdxWidth-1:0]  idx_q   [NumRules];
  logic [IdxWidth-1:0]  idx_d   [NumRules];
  logic [NumRules-1:0]  en_q, en_d;
  logic                 lock_q, lock_d;
  logic [31:0]          miss_cnt_q, miss_cnt_d;
  logic [31:0]          cfg_rdata_q, cfg_rdata_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 rs_valid_q, rs_valid_d;
  logic [IdxWidth-1:0]  rs_idx_q, rs_idx_d;
  logic                 rs_hit_q, rs_hit_d;
  logic                 rs_decerr_q, rs_decerr_d;

  logic                 cnt_clr;
  logic                 lk_accept;
  logic                 match_hit;
  logic [IdxWidth-1:0]  match_idx;
  logic [11:0]          rule_off;
  logic [6:0]           rule_sel;
  logic [4:0]           rule_field;
  logic [63:0]          start_ext, end_ext;
  logic                 field_ok;

  assign rule_off   = cfg_addr_i - REG_RULE_BASE;
  assign rule_sel   = rule_off[11:5];
  assign rule_field = rule_off[4:0];

  assign cfg_gnt_o = cfg_req_i;
  assign lk_ready_o = !rs_valid_q || rs_ready_i;
  assign lk_accept  = lk_valid_i && lk_ready_o;

  lagd_dec_match #(
    .NumRules  (NumRules),
    .AddrWidth (AddrWidth),
    .IdxWidth  (IdxWidth)
  ) u_match (
    .start_i (start_q),
    .end_i   (end_q),
    .idx_i   (idx_q),
    .en_i    (en_q),
    .addr_i  (lk_addr_i),
    .idx_o   (match_idx),
    .hit_o   (match_hit)
  );

  always_comb begin
    start_d     = start_q;
    end_d       = end_q;
    idx_d       = idx_q;
    en_d        = en_q;
    lock_d      = lock_q;
    cfg_rdata_d = '0;
    cfg_err_d   = 1'b0;
    cnt_clr     = 1'b0;
    start_ext   = '0;
    end_ext     = '0;
    field_ok    = 1'b0;
    if (cfg_req_i) begin
      if (cfg_addr_i[1:0] != 2'b00) begin
        cfg_err_d = 1'b1;
      end else if (cfg_addr_i == REG_LOCK) begin
        if (cfg_we_i) lock_d = lock_q | cfg_wdata_i[0];
        else          cfg_rdata_d = {31'b0, lock_q};
      end else if (cfg_addr_i == REG_MISS_CNT) begin
        if (cfg_we_i) cnt_clr = 1'b1;
        else          cfg_rdata_d = miss_cnt_q;
      end else if (cfg_addr_i >= REG_RULE_BASE) begin
        for (int i = 0; i < int'(NumRules); i++) begin
          if (rule_sel == 7'(i)) begin
            start_ext = 64'(start_q[i]);
            end_ext   = 64'(end_q[i]);
            field_ok  = 1'b1;
            // Table writes are dropped once locked; reads stay available.
            case (rule_field)
              OFF_START_LO: begin
                cfg_rdata_d = start_ext[31:0];
                if (cfg_we_i && !lock_q) start_d[i] = AddrWidth'({start_ext[63:32], cfg_wdata_i});
              end
              OFF_START_HI: begin
                cfg_rdata_d = start_ext[63:32];
                if (cfg_we_i && !lock_q) start_d[i] = AddrWidth'({cfg_wdata_i, start_ext[31:0]});
              end
              OFF_END_LO: begin
                cfg_rdata_d = end_ext[31:0];
                if (cfg_we_i && !lock_q) end_d[i] = AddrWidth'({end_ext[63:32], cfg_wdata_i});
              end
              OFF_END_HI: begin
                cfg_rdata_d = end_ext[63:32];
                if (cfg_we_i && !lock_q) end_d[i] = AddrWidth'({cfg_wdata_i, end_ext[31:0]});
              end
              OFF_CTRL: begin
                cfg_rdata_d = 32'({idx_q[i], 8'h00}) | {31'b0, en_q[i]};
                if (cfg_we_i && !lock_q) begin
                  en_d[i]  = cfg_wdata_i[0];
                  idx_d[i] = cfg_wdata_i[IdxWidth+7:8];
                end
              end
              default: field_ok = 1'b0;
            endcase
          end
        end
        if (cfg_we_i || !field_ok) cfg_rdata_d = '0;
        cfg_err_d = !field_ok || (cfg_we_i && lock_q);
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    rs_valid_d  = rs_valid_q;
    rs_idx_d    = rs_idx_q;
    rs_hit_d    = rs_hit_q;
    rs_decerr_d = rs_decerr_q;
    miss_cnt_d  = miss_cnt_q;
    if (lk_accept) begin
      rs_valid_d = 1'b1;
      if (match_hit) begin
        rs_idx_d    = match_idx;
        rs_hit_d    = 1'b1;
        rs_decerr_d = 1'b0;
      end else begin
        rs_idx_d    = DefaultEn ? DefaultIdx : '0;
        rs_hit_d    = 1'b0;
        rs_decerr_d = !DefaultEn;
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end else if (rs_ready_i) begin
      rs_valid_d = 1'b0;
    end
    // A clear landing in the same cycle as a miss wins.
    if (cnt_clr) miss_cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int r = 0; r < int'(NumRules); r++) begin
        start_q[r] <= AddrWidth'(rst_start(r));
        end_q[r]   <= AddrWidth'(rst_end(r));
        idx_q[r]   <= IdxWidth'(rst_idx(r));
        en_q[r]    <= rst_en(r);
      end
      lock_q      <= 1'b0;
      miss_cnt_q  <= '0;
      cfg_rdata_q <= '0;
      cfg_err_q   <= 1'b0;
      rs_valid_q  <= 1'b0;
      rs_idx_q    <= '0;
      rs_hit_q    <= 1'b0;
      rs_decerr_q <= 1'b0;
    end else begin
      start_q     <= start_d;
      end_q       <= end_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      lock_q      <= lock_d;
      miss_cnt_q  <= miss_cnt_d;
      cfg_rdata_q <= cfg_rdata_d;
      cfg_err_q   <= cfg_err_d;
      rs_valid_q  <= rs_valid_d;
      rs_idx_q    <= rs_idx_d;
      rs_hit_q    <= rs_hit_d;
      rs_decerr_q <= rs_decerr_d;
    end
  end

  assign cfg_rdata_o = cfg_rdata_q;
  assign cfg_err_o   = cfg_err_q;
  assign rs_valid_o  = rs_valid_q;
  assign rs_idx_o    = rs_idx_q;
  assign rs_hit_o    = rs_hit_q;
  assign rs_decerr_o = rs_decerr_q;

endmodule

// File: tb/tb_lagd_prog_addr_decoder.sv
// Scoreboard bench for lagd_prog_addr_decoder: stimulus pushes expected lookup
// results and register responses; independent monitors pop and compare them.
module tb_lagd_prog_addr_decoder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_req_i = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [11:0] cfg_addr_i = '0;
  logic [31:0] cfg_wdata_i = '0;
  logic        cfg_gnt_o;
  logic [31:0] cfg_rdata_o;
  logic        cfg_err_o;
  logic        lk_valid_i = 1'b0;
  logic        lk_ready_o;
  logic [47:0] lk_addr_i = '0;
  logic        rs_valid_o;
  logic        rs_ready_i = 1'b1;
  logic [3:0]  rs_idx_o;
  logic        rs_hit_o;
  logic        rs_decerr_o;

  typedef struct packed {
    logic [3:0] idx;
    logic       hit;
    logic       decerr;
  } lk_exp_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } cfg_exp_t;

  lk_exp_t  lk_exp_q  [$];
  cfg_exp_t cfg_exp_q [$];
  lk_exp_t  lk_exp;
  cfg_exp_t cfg_exp;
  int       total = 0;
  int       bad = 0;
  logic     cfg_seen = 1'b0;

  lagd_prog_addr_decoder dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cfg_req_i   (cfg_req_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_wdata_i (cfg_wdata_i),
    .cfg_gnt_o   (cfg_gnt_o),
    .cfg_rdata_o (cfg_rdata_o),
    .cfg_err_o   (cfg_err_o),
    .lk_valid_i  (lk_valid_i),
    .lk_ready_o  (lk_ready_o),
    .lk_addr_i   (lk_addr_i),
    .rs_valid_o  (rs_valid_o),
    .rs_ready_i  (rs_ready_i),
    .rs_idx_o    (rs_idx_o),
    .rs_hit_o    (rs_hit_o),
    .rs_decerr_o (rs_decerr_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Lookup results leave the DUT on a valid && ready handshake.
  always @(negedge clk_i) begin
    if (rst_ni && rs_valid_o && rs_ready_i) begin
      if (lk_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got idx=%0d hit=%0b decerr=%0b, expected none",
                 rs_idx_o, rs_hit_o, rs_decerr_o);
      end else begin
        lk_exp = lk_exp_q.pop_front();
        checkOutput("rs_idx_hit_decerr", 64'({rs_idx_o, rs_hit_o, rs_decerr_o}), 64'(lk_exp));
      end
    end
  end

  always @(posedge clk_i) cfg_seen <= cfg_req_i && rst_ni;

  // Register responses appear the cycle after the granted request.
  always @(negedge clk_i) begin
    if (cfg_seen) begin
      if (cfg_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_cfg: got rdata=0x%0h err=%0b, expected none", cfg_rdata_o, cfg_err_o);
      end else begin
        cfg_exp = cfg_exp_q.pop_front();
        checkOutput("cfg_rdata_err", 64'({cfg_rdata_o, cfg_err_o}), 64'(cfg_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    rst_ni     = 1'b0;
    lk_valid_i = 1'b0;
    cfg_req_i  = 1'b0;
    tick();
    tick();
    lk_exp_q.delete();
    cfg_exp_q.delete();
    rst_ni = 1'b1;
  endtask

  // Presents one lookup and returns right after it was accepted; lk_valid_i stays high.
  task automatic applyStimulus(input logic [47:0] addr, input logic [3:0] e_idx, input logic e_hit, input logic e_dec);
    int waited;
    lk_valid_i = 1'b1;
    lk_addr_i  = addr;
    lk_exp_q.push_back('{idx: e_idx, hit: e_hit, decerr: e_dec});
    #1;
    waited = 0;
    while (!lk_ready_o && waited < 20) begin
      tick();
      waited++;
    end
    if (!lk_ready_o) begin
      total++;
      bad++;
      $display("[TB] FAIL lk_accept_timeout: got ready=0, expected ready=1 within 20 cycles");
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfgAccess(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [31:0] e_rdata, input logic e_err);
    cfg_req_i   = 1'b1;
    cfg_we_i    = we;
    cfg_addr_i  = addr;
    cfg_wdata_i = wdata;
    cfg_exp_q.push_back('{rdata: e_rdata, err: e_err});
    #1;
    checkOutput("cfg_gnt", 64'(cfg_gnt_o), 64'd1);
    @(posedge clk_i);
    #1;
    cfg_req_i = 1'b0;
    cfg_we_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    doReset();
    checkOutput("rst_rs_valid", 64'(rs_valid_o), 64'd0);
    checkOutput("rst_rs_idx", 64'(rs_idx_o), 64'd0);
    checkOutput("rst_rs_hit", 64'(rs_hit_o), 64'd0);
    checkOutput("rst_rs_decerr", 64'(rs_decerr_o), 64'd0);
    checkOutput("rst_cfg_rdata", 64'(cfg_rdata_o), 64'd0);
    checkOutput("rst_cfg_err", 64'(cfg_err_o), 64'd0);
    checkOutput("rst_lk_ready", 64'(lk_ready_o), 64'd1);

    $display("[TB] basic lookup into L2 window");
    applyStimulus(48'h0000_7000_0010, 4'd0, 1'b1, 1'b0);
    checkOutput("latency_rs_valid", 64'(rs_valid_o), 64'd1);
    lk_valid_i = 1'b0;
    tick();

    $display("[TB] back-pressure");
    rs_ready_i = 1'b0;
    applyStimulus(48'h0000_8100_0000, 4'd2, 1'b1, 1'b0);
    lk_valid_i = 1'b1;
    lk_addr_i  = 48'h0000_8200_0000;
    lk_exp_q.push_back('{idx: 4'd3, hit: 1'b1, decerr: 1'b0});
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_lk_ready", 64'(lk_ready_o), 64'd0);
      checkOutput("bp_hold_valid", 64'(rs_valid_o), 64'd1);
      checkOutput("bp_hold_idx", 64'(rs_idx_o), 64'd2);
      tick();
    end
    rs_ready_i = 1'b1;
    tick();
    applyStimulus(48'h0000_7000_0000, 4'd0, 1'b1, 1'b0);
    applyStimulus(48'h0000_8300_0010, 4'd4, 1'b1, 1'b0);
    lk_valid_i = 1'b0;
    tick();

    $display("[TB] overlapping windows and priority");
    cfgAccess(1'b1, 12'h140, 32'h8000_0000, 32'h0, 1'b0);
    cfgAccess(1'b1, 12'h144, 32'h0000_0000, 32'h0, 1'b0);
    applyStimulus(48'h0000_8000_0000, 4'd1, 1'b1, 1'b0);
    lk_valid_i = 1'b0;
    cfgAccess(1'b1, 12'h130, 32'h0000_0100, 32'h0, 1'b0);
    applyStimulus(48'h0000_8000_0000, 4'd2, 1'b1, 1'b0);
    lk_valid_i = 1'b0;
    cfgAccess(1'b0, 12'h130, 32'h0, 32'h0000_0100, 1'b0);
    cfgAccess(1'b0, 12'h140, 32'h0, 32'h8000_0000, 1'b0);
    cfgAccess(1'b0, 12'h150, 32'h0, 32'h0000_0201, 1'b0);

    $display("[TB] miss and miss counter");
    applyStimulus(48'h0000_FFFF_0000, 4'd0, 1'b0, 1'b1);
    lk_valid_i = 1'b0;
    cfgAccess(1'b0, 12'h004, 32'h0, 32'd1, 1'b0);
    cfgAccess(1'b1, 12'h004, 32'h1234_5678, 32'h0, 1'b0);
    cfgAccess(1'b0, 12'h004, 32'h0, 32'd0, 1'b0);

    $display("[TB] high address bits and start > end");
    cfgAccess(1'b1, 12'h164, 32'hFFFF_1234, 32'h0, 1'b0);
    cfgAccess(1'b0, 12'h164, 32'h0, 32'h0000_1234, 1'b0);
    applyStimulus(48'h0000_8200_0000, 4'd0, 1'b0, 1'b1);
    lk_valid_i = 1'b0;
    cfgAccess(1'b1, 12'h164, 32'h0, 32'h0, 1'b0);
    applyStimulus(48'h0000_8200_0000, 4'd3, 1'b1, 1'b0);
    applyStimulus(48'h0000_82FF_FFFF, 4'd3, 1'b1, 1'b0);
    lk_valid_i = 1'b0;

    $display("[TB] access errors");
    cfgAccess(1'b0, 12'h008, 32'h0, 32'h0, 1'b1);
    cfgAccess(1'b0, 12'h102, 32'h0, 32'h0, 1'b1);
    cfgAccess(1'b0, 12'h200, 32'h0, 32'h0, 1'b1);
    cfgAccess(1'b1, 12'h114, 32'hFFFF_FFFF, 32'h0, 1'b1);

    $display("[TB] same-cycle table write and lookup");
    cfg_req_i   = 1'b1;
    cfg_we_i    = 1'b1;
    cfg_addr_i  = 12'h108;
    cfg_wdata_i = 32'h7FFF_FF00;
    cfg_exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    lk_valid_i = 1'b1;
    lk_addr_i  = 48'h0000_7FFF_FFFF;
    lk_exp_q.push_back('{idx: 4'd0, hit: 1'b1, decerr: 1'b0});
    #1;
    checkOutput("same_cycle_lk_ready", 64'(lk_ready_o), 64'd1);
    tick();
    cfg_req_i = 1'b0;
    cfg_we_i  = 1'b0;
    applyStimulus(48'h0000_7FFF_FFFF, 4'd0, 1'b0, 1'b1);
    applyStimulus(48'h0000_7FFF_FF00, 4'd0, 1'b1, 1'b0);
    lk_valid_i = 1'b0;

    $display("[TB] lock");
    cfgAccess(1'b1, 12'h000, 32'h1, 32'h0, 1'b0);
    cfgAccess(1'b0, 12'h000, 32'h0, 32'h1, 1'b0);
    cfgAccess(1'b1, 12'h160, 32'h0000_1234, 32'h0, 1'b1);
    cfgAccess(1'b0, 12'h160, 32'h0, 32'h8200_0000, 1'b0);

    $display("[TB] reset with a result in flight");
    rs_ready_i = 1'b0;
    applyStimulus(48'h0000_8100_0000, 4'd2, 1'b1, 1'b0);
    lk_valid_i = 1'b0;
    doReset();
    rs_ready_i = 1'b1;
    checkOutput("rst2_rs_valid", 64'(rs_valid_o), 64'd0);
    checkOutput("rst2_rs_idx", 64'(rs_idx_o), 64'd0);
    cfgAccess(1'b0, 12'h000, 32'h0, 32'h0, 1'b0);
    cfgAccess(1'b0, 12'h160, 32'h0, 32'h8200_0000, 1'b0);
    cfgAccess(1'b0, 12'h108, 32'h0, 32'h7FFF_FFFF, 1'b0);
    cfgAccess(1'b0, 12'h140, 32'h0, 32'h8100_0000, 1'b0);
    cfgAccess(1'b1, 12'h160, 32'h8200_0000, 32'h0, 1'b0);
    applyStimulus(48'h0000_8000_0000, 4'd1, 1'b1, 1'b0);
    applyStimulus(48'h0000_7FFF_FFFF, 4'd0, 1'b1, 1'b0);
    lk_valid_i = 1'b0;

    waited = 0;
    while ((lk_exp_q.size() != 0 || cfg_exp_q.size() != 0) && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("drain_pending", 64'(lk_exp_q.size() + cfg_exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
